// File: rtl/masked_share_gen.sv
// masked_share_gen: split plain operands into two Boolean shares behind a 2-entry skid buffer
//
// Masks come from a free-running Galois LFSR. Each accepted operand pair is
// stored as {a^m_a, m_a, b^m_b, m_b, c_in}, so that a0^a1 == a and b0^b1 == b.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready is low only while the skid slot is full)
//   a, b, c_in         plain operands and carry-in
//   reseed_valid, seed load a new LFSR state (a zero seed falls back to SEED)
//   out_valid/out_ready downstream handshake
//   a0, a1, b0, b1     shares of a and b
//   c_out              carry-in forwarded unmasked
module masked_share_gen #(
   parameter int                N      = 4,
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
   parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      a,
   input  logic [N-1:0]      b,
   input  logic              c_in,
   input  logic              reseed_valid,
   input  logic [LFSR_W-1:0] seed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      a0,
   output logic [N-1:0]      a1,
   output logic [N-1:0]      b0,
   output logic [N-1:0]      b1,
   output logic              c_out
);
   localparam int W = 4*N + 1;

   if (2*N > LFSR_W) begin : g_bad_width
      $error("masked_share_gen: 2*N must not exceed LFSR_W");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("masked_share_gen: SEED must be nonzero");
   end

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [W-1:0]      or_q, or_d, sk_q, sk_d, entry;
   logic              or_v_q, or_v_d, sk_v_q, sk_v_d;
   logic              accept, load;
   logic [N-1:0]      m_a, m_b;

   assign m_a = lfsr_q[N-1:0];
   assign m_b = lfsr_q[2*N-1:N];

   always_comb begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
      if (reseed_valid) lfsr_d = (seed == '0) ? SEED : seed;
      accept = in_valid & ~sk_v_q;
      // OR can take new data when it is empty or is being drained this edge
      load   = ~or_v_q | out_ready;
      entry  = {a ^ m_a, m_a, b ^ m_b, m_b, c_in};
      or_v_d = or_v_q;
      or_d   = or_q;
      sk_v_d = sk_v_q;
      sk_d   = sk_q;
      if (load) begin
         // the skid entry is older than any new accept, so it goes first
         or_v_d = sk_v_q | accept;
         or_d   = sk_v_q ? sk_q : (accept ? entry : or_q);
         sk_v_d = sk_v_q & accept;
         sk_d   = (sk_v_q & accept) ? entry : sk_q;
      end else if (accept) begin
         sk_v_d = 1'b1;
         sk_d   = entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
         or_q   <= '0;
         or_v_q <= 1'b0;
         sk_q   <= '0;
         sk_v_q <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         or_q   <= or_d;
         or_v_q <= or_v_d;
         sk_q   <= sk_d;
         sk_v_q <= sk_v_d;
      end
   end

   assign {a0, a1, b0, b1, c_out} = or_q;
   assign out_valid = or_v_q;
   assign in_ready  = ~sk_v_q;
endmodule

// File: tb/tb_masked_share_gen.sv
// tb_masked_share_gen: randomized bench for masked_share_gen against a queue-based reference model
module tb_masked_share_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, c_in = 1'b0, reseed_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  a = '0, b = '0;
   logic [15:0] seed = '0;
   logic        in_ready, out_valid, c_out;
   logic [3:0]  a0, a1, b0, b1;

   int          total = 0, bad = 0;
   logic [16:0] q[$];
   logic [15:0] mlfsr = 16'hACE1;
   bit          acc_last;
   int          n_acc;
   logic [15:0] seen_a1;

   masked_share_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .reseed_valid(reseed_valid), .seed(seed),
      .out_valid(out_valid), .out_ready(out_ready),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c_out(c_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, update the model at the edge, then compare.
   task automatic step(input logic iv, input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                       input logic ordy, input logic rv, input logic [15:0] sd);
      bit acc, fire;
      logic [3:0] ma, mb;
      in_valid = iv; a = ia; b = ib; c_in = ic; out_ready = ordy; reseed_valid = rv; seed = sd;
      @(posedge clk);
      acc  = iv && (q.size() < 2);
      fire = (q.size() > 0) && ordy;
      ma = mlfsr[3:0];
      mb = mlfsr[7:4];
      if (fire) void'(q.pop_front());
      if (acc) q.push_back({ia ^ ma, ma, ib ^ mb, mb, ic});
      if (rv) mlfsr = (sd == 16'h0) ? 16'hACE1 : sd;
      else    mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
      acc_last = acc;
      if (acc) n_acc++;
      #1;
      check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) check("data", {15'b0, a0, a1, b0, b1, c_out}, {15'b0, q[0]});
      check("lfsr", {16'b0, dut.lfsr_q}, {16'b0, mlfsr});
   endtask

   initial begin
      int cyc;
      logic [3:0] ra, rb;
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_in_ready", {31'b0, in_ready}, 1);
      check("rst_data", {15'b0, a0, a1, b0, b1, c_out}, 0);
      check("rst_lfsr", {16'b0, dut.lfsr_q}, 32'hACE1);
      rst_n = 1'b1;

      // first accept right after reset release
      step(1, 4'h5, 4'h3, 1, 1, 0, 0);
      check("t1_a0", {28'b0, a0}, 4'h4);
      check("t1_a1", {28'b0, a1}, 4'h1);
      check("t1_b0", {28'b0, b0}, 4'hD);
      check("t1_b1", {28'b0, b1}, 4'hE);
      check("t1_c", {31'b0, c_out}, 1);
      check("t1_lfsr", {16'b0, dut.lfsr_q}, 32'hE270);
      step(0, 0, 0, 0, 1, 0, 0);

      // backpressure: A to OR, B to skid, C held
      step(1, 4'hA, 4'h1, 0, 0, 0, 0);
      step(1, 4'hB, 4'h2, 1, 0, 0, 0);
      check("bp_in_ready_low", {31'b0, in_ready}, 0);
      step(1, 4'hC, 4'h3, 0, 0, 0, 0);
      check("bp_c_held", {31'b0, acc_last}, 0);
      cyc = 0;
      do begin
         step(1, 4'hC, 4'h3, 0, 1, 0, 0);
         cyc++;
      end while (!acc_last && cyc < 10);
      check("bp_c_accepted", {31'b0, acc_last}, 1);
      repeat (3) step(0, 0, 0, 0, 1, 0, 0);
      check("bp_drained", {31'b0, out_valid}, 0);

      // reseed
      step(0, 0, 0, 0, 1, 1, 16'h0001);
      check("reseed_1", {16'b0, dut.lfsr_q}, 32'h0001);
      step(0, 0, 0, 0, 1, 1, 16'h0000);
      check("reseed_0", {16'b0, dut.lfsr_q}, 32'hACE1);
      // reseed and accept together: masks from ACE1 (m_a=1, m_b=E)
      step(1, 4'h0, 4'h0, 0, 1, 1, 16'h1234);
      check("reseed_acc_a1", {28'b0, a1}, 4'h1);
      check("reseed_acc_b1", {28'b0, b1}, 4'hE);
      check("reseed_acc_lfsr", {16'b0, dut.lfsr_q}, 32'h1234);
      step(0, 0, 0, 0, 1, 0, 0);

      // random soak
      n_acc = 0;
      seen_a1 = '0;
      cyc = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         step(($urandom % 4) != 0, ra, rb, 1'($urandom), ($urandom % 3) != 0,
              ($urandom % 64) == 0, (($urandom % 4) == 0) ? 16'h0 : 16'($urandom));
         if (out_valid) seen_a1[a1] = 1'b1;
         cyc++;
      end
      check("soak_count", n_acc, 10000);
      check("soak_a1_varies", {31'b0, $countones(seen_a1) > 1}, 1);

      // async reset with skid full
      repeat (3) step(0, 0, 0, 0, 1, 0, 0);
      step(1, 4'h7, 4'h8, 1, 0, 0, 0);
      step(1, 4'h9, 4'h6, 0, 0, 0, 0);
      check("pre_rst_sk_full", {31'b0, in_ready}, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 0);
      check("arst_in_ready", {31'b0, in_ready}, 1);
      check("arst_data", {15'b0, a0, a1, b0, b1, c_out}, 0);
      q.delete();
      mlfsr = 16'hACE1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0);
      check("post_rst_no_stale", {31'b0, out_valid}, 0);
      step(1, 4'h5, 4'h3, 1, 1, 0, 0);
      check("post_rst_a0", {28'b0, a0}, 4'h5 ^ 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
